// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input and
// reports duty on an 8-bit scale (128 = 50 %, 255 = full on) through an 8-step
// serial divider. A stale flag is raised when the input stops toggling.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period_w,
    output logic [CNT_W-1:0] high_w,
    output logic [7:0]       duty,
    output logic             valid,
    output logic             stale,
    output logic             ovr
);

    typedef enum logic [1:0] {IDLE = 2'd0, MEAS = 2'd1, DIV = 2'd2} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise, fall;
    logic [CNT_W-1:0]       pc, hc;
    logic                   hf, sat;
    logic [3:0]             step, step_n;
    logic [CNT_W-1:0]       p_q, p_n, h_q, h_n, r_q, r_n, r_sub;
    logic [CNT_W:0]         r_sh;
    logic                   r_ge;
    logic [7:0]             q_q, q_n, q_step;
    logic [CNT_W-1:0]       period_n, high_n;
    logic [7:0]             duty_n;
    logic                   valid_n, stale_n, ovr_n, drop, go_idle;

    // Input synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;
    assign sat  = &pc;

    // One restoring-division step: the remainder always stays below P, so
    // the shifted value needs only one extra bit and the difference fits CNT_W.
    assign r_sh   = {r_q, 1'b0};
    assign r_ge   = (r_sh >= {1'b0, p_q});
    assign r_sub  = r_sh[CNT_W-1:0] - p_q;
    assign q_step = {q_q[6:0], r_ge};

    // Period/high counters: restart on every rise, frozen while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            hc <= '0;
            hf <= 1'b0;
        end else if (rise) begin
            pc <= {{(CNT_W-1){1'b0}}, 1'b1};
            hc <= {{(CNT_W-1){1'b0}}, 1'b1};
            hf <= 1'b0;
        end else if (state != IDLE) begin
            if (!sat)
                pc <= pc + 1'b1;
            if (fall)
                hf <= 1'b1;
            else if (s && !hf)
                hc <= hc + 1'b1;
        end
    end

    // State, divider and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            p_q      <= '0;
            h_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            period_w <= '0;
            high_w   <= '0;
            duty     <= '0;
            valid    <= 1'b0;
            stale    <= 1'b1;
            ovr      <= 1'b0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            p_q      <= p_n;
            h_q      <= h_n;
            r_q      <= r_n;
            q_q      <= q_n;
            period_w <= period_n;
            high_w   <= high_n;
            duty     <= duty_n;
            valid    <= valid_n;
            stale    <= stale_n;
            ovr      <= ovr_n;
        end
    end

    // Next-state: arm on first rise, capture on later rises, divide for
    // 8 steps plus one settle cycle during which rises are still dropped.
    always_comb begin
        state_n  = state;
        step_n   = step;
        p_n      = p_q;
        h_n      = h_q;
        r_n      = r_q;
        q_n      = q_q;
        period_n = period_w;
        high_n   = high_w;
        duty_n   = duty;
        valid_n  = 1'b0;
        stale_n  = stale;
        drop     = 1'b0;
        go_idle  = 1'b0;
        case (state)
            IDLE: begin
                if (rise)
                    state_n = MEAS;
            end
            MEAS: begin
                if (sat) begin
                    go_idle = 1'b1;
                end else if (rise) begin
                    p_n     = pc;
                    h_n     = hc;
                    r_n     = hc;
                    q_n     = '0;
                    step_n  = '0;
                    state_n = DIV;
                end
            end
            DIV: begin
                if (sat) begin
                    go_idle = 1'b1;
                end else begin
                    drop = rise;
                    if (step == 4'd8) begin
                        state_n = MEAS;
                    end else begin
                        r_n    = r_ge ? r_sub : r_sh[CNT_W-1:0];
                        q_n    = q_step;
                        step_n = step + 4'd1;
                        if (step == 4'd7) begin
                            period_n = p_q;
                            high_n   = h_q;
                            duty_n   = (h_q >= p_q) ? 8'hFF : q_step;
                            valid_n  = 1'b1;
                            stale_n  = 1'b0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (go_idle) begin
            state_n  = IDLE;
            stale_n  = 1'b1;
            period_n = '0;
            high_n   = '0;
            duty_n   = '0;
        end
        ovr_n = drop ? 1'b1 : (clr ? 1'b0 : ovr);
    end

endmodule
